// File: rtl/wb_spi_host_master_pkg.sv
// Shared types and default sizes for the Wishbone host master that talks to
// the SPI controller's register port.
package wb_spi_host_pkg;

   localparam int TIMEOUT_CYC_DEF = 64;
   localparam int AW_DEF          = 5;
   localparam int DW_DEF          = 32;
   localparam int SW_DEF          = DW_DEF / 8;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_e;

   // Command as held on the Wishbone outputs for the duration of a cycle.
   typedef struct packed {
      logic              we;
      logic [AW_DEF-1:0] adr;
      logic [DW_DEF-1:0] dat;
      logic [SW_DEF-1:0] sel;
   } req_t;

   // Result of one bus cycle, held until the host consumes it.
   typedef struct packed {
      logic [DW_DEF-1:0] dat;
      logic              err;
      logic              timeout;
   } rsp_t;

endpackage

// File: rtl/wb_spi_host_master_if.sv
// Command/response stream plus Wishbone master signals of the host master.
// The master modport is the host master's view; slave is the environment's.
interface wb_spi_host_master_if #(
   parameter int AW = wb_spi_host_pkg::AW_DEF,
   parameter int DW = wb_spi_host_pkg::DW_DEF
);
   localparam int SW = DW / 8;

   // command stream
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_adr;
   logic [DW-1:0] req_dat;
   logic [SW-1:0] req_sel;

   // response stream
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_dat;
   logic          rsp_err;
   logic          rsp_timeout;

   // Wishbone bus
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic [SW-1:0] wb_sel_o;
   logic          wb_we_o;
   logic          wb_stb_o;
   logic          wb_cyc_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack_i;
   logic          wb_err_i;

   modport master (
      input  req_valid, req_we, req_adr, req_dat, req_sel, rsp_ready,
             wb_dat_i, wb_ack_i, wb_err_i,
      output req_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout,
             wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o
   );

   modport slave (
      output req_valid, req_we, req_adr, req_dat, req_sel, rsp_ready,
             wb_dat_i, wb_ack_i, wb_err_i,
      input  req_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout,
             wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o
   );

endinterface

// File: rtl/wb_spi_host_master_irq_latch.sv
// Sticky interrupt pending flag: set on a rising edge of the SPI core's
// interrupt, cleared by a host pulse; a new edge beats a clear.
module wb_irq_latch (
   input  logic clock,
   input  logic rst_n,
   input  logic int_i,
   input  logic clr_i,
   output logic pend_o
);

   logic int_q;
   logic pend_q, pend_d;

   // Next pending value: clear first, then let a rising edge override it.
   // NOTE: the default assignment at the top keeps pend_d driven on every path, so no latch is inferred.
   always_comb begin
      pend_d = pend_q;
      if (clr_i) begin
         pend_d = 1'b0;
      end
      if (int_i && !int_q) begin
         pend_d = 1'b1;
      end
   end

   // Previous interrupt level for edge detection, plus the pending flag.
   // NOTE: non-blocking assignments so every register samples pre-edge values together.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         int_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         int_q  <= int_i;
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;

endmodule

// File: rtl/wb_spi_host_master.sv
// Wishbone classic master: one bus cycle per accepted command, result returned
// on a response stream. Bus widths are carried by the interface instance.
// A bus cycle ends on ack/err or, when TIMEOUT_CYC is non-zero, after
// TIMEOUT_CYC strobe cycles without either.
module wb_spi_host_master
   import wb_spi_host_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                 clock,
   input  logic                 rst_n,
   wb_spi_host_master_if.master bus,
   input  logic                 wb_int_i,
   input  logic                 irq_clr,
   output logic                 irq_pend
);

   localparam bit              TO_EN      = (TIMEOUT_CYC > 0);
   localparam int              TW         = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TW-1:0]   TIMER_LAST = TW'(TO_EN ? TIMEOUT_CYC - 1 : 0);

   state_e          state_q, state_d;
   req_t            req_q,   req_d;
   rsp_t            rsp_q,   rsp_d;
   logic            cyc_q,   cyc_d;
   logic            rdy_q,   rdy_d;
   logic [TW-1:0]   timer_q, timer_d;

   // Next state, bus command, response capture and wait timer.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rsp_d   = rsp_q;
      cyc_d   = cyc_q;
      rdy_d   = rdy_q;
      timer_d = timer_q;

      unique case (state_q)
         IDLE: begin
            rdy_d = 1'b1;
            if (bus.req_valid && rdy_q) begin
               req_d.we  = bus.req_we;
               req_d.adr = bus.req_adr;
               req_d.dat = bus.req_dat;
               req_d.sel = bus.req_sel;
               cyc_d     = 1'b1;
               rdy_d     = 1'b0;
               timer_d   = '0;
               state_d   = BUS;
            end
         end
         BUS: begin
            // err outranks ack, and either outranks the timeout on the same edge
            if (bus.wb_err_i) begin
               rsp_d   = '{dat: '0, err: 1'b1, timeout: 1'b0};
               cyc_d   = 1'b0;
               state_d = RESP;
            end else if (bus.wb_ack_i) begin
               rsp_d   = '{dat: req_q.we ? '0 : bus.wb_dat_i, err: 1'b0, timeout: 1'b0};
               cyc_d   = 1'b0;
               state_d = RESP;
            end else if (TO_EN && timer_q == TIMER_LAST) begin
               rsp_d   = '{dat: '0, err: 1'b1, timeout: 1'b1};
               cyc_d   = 1'b0;
               state_d = RESP;
            end else if (TO_EN) begin
               timer_d = timer_q + 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rdy_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset discards any in-flight command.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         rsp_q   <= '0;
         cyc_q   <= 1'b0;
         rdy_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rsp_q   <= rsp_d;
         cyc_q   <= cyc_d;
         rdy_q   <= rdy_d;
         timer_q <= timer_d;
      end
   end

   assign bus.req_ready   = rdy_q;
   assign bus.rsp_valid   = (state_q == RESP);
   assign bus.rsp_dat     = rsp_q.dat;
   assign bus.rsp_err     = rsp_q.err;
   assign bus.rsp_timeout = rsp_q.timeout;

   assign bus.wb_adr_o    = req_q.adr;
   assign bus.wb_dat_o    = req_q.dat;
   assign bus.wb_sel_o    = req_q.sel;
   assign bus.wb_we_o     = req_q.we;
   assign bus.wb_stb_o    = cyc_q;
   assign bus.wb_cyc_o    = cyc_q;

   wb_irq_latch u_irq (
      .clock  (clock),
      .rst_n  (rst_n),
      .int_i  (wb_int_i),
      .clr_i  (irq_clr),
      .pend_o (irq_pend)
   );

endmodule
